pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline register carrying {pc, ir, data} between core stages; successor to the

---
 rtl/pipe_stage_elastic.sv | 110 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register for {pc, ir, data}: valid/ready handshake, main + skid storage,
// stall freeze, flush-to-bubble and a saturating count of entries killed by flush.
module pipe_stage_elastic #(
    parameter int unsigned         PC_W     = 32,
    parameter int unsigned         IR_W     = 32,
    parameter int unsigned         DATA_W   = 64,
    parameter logic [IR_W-1:0]     NOP_INST = 32'h00000013,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [IR_W-1:0]   out_ir,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   main_pc,   skid_pc;
    logic [IR_W-1:0]   main_ir,   skid_ir;
    logic [DATA_W-1:0] main_data, skid_data;

    logic              acc;
    logic              dep;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [CNT_W:0]    kill_sum;

    // in_ready depends only on registered state and stage controls, never on out_ready
    assign in_ready  = rst & ~stall & ~flush & (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign acc       = in_valid & in_ready;
    assign dep       = out_valid & out_ready & ~stall;

    assign load_main_in   = acc & ((state == EMPTY) | ((state == ONE) & dep));
    assign load_main_skid = (state == FULL) & dep & ~flush;
    assign load_skid      = acc & (state == ONE) & ~dep;

    assign kill_sum = {1'b0, kill_cnt} + (CNT_W+1)'(occupancy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            kill_cnt <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            kill_cnt <= kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
        end else begin
            unique case (state)
                EMPTY:   if (acc) state <= ONE;
                ONE:     if (acc && !dep) state <= FULL;
                         else if (!acc && dep) state <= EMPTY;
                FULL:    if (dep) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pc   <= '0;
            main_ir   <= NOP_INST;
            main_data <= '0;
        end else if (load_main_in) begin
            main_pc   <= in_pc;
            main_ir   <= in_ir;
            main_data <= in_data;
        end else if (load_main_skid) begin
            main_pc   <= skid_pc;
            main_ir   <= skid_ir;
            main_data <= skid_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pc   <= '0;
            skid_ir   <= NOP_INST;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_pc   <= in_pc;
            skid_ir   <= in_ir;
            skid_data <= in_data;
        end
    end

    // main regs keep stale contents after dequeue; an empty stage presents a bubble instead
    assign out_pc   = out_valid ? main_pc   : '0;
    assign out_ir   = out_valid ? main_ir   : NOP_INST;
    assign out_data = out_valid ? main_data : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: streaming, back-pressure, flush, stall, kill saturation
// and asynchronous reset; a second instance with CNT_W=2 covers counter saturation.
module tb_pipe_stage_elastic;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_ir;
    logic [63:0] in_data;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_ir;
    logic [63:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] kill_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] out_pc2, out_ir2;
    logic [63:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  kill_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.PC_W(32), .IR_W(32), .DATA_W(64), .NOP_INST(32'h00000013), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
        .out_data(out_data), .occupancy(occupancy), .kill_cnt(kill_cnt)
    );

    pipe_stage_elastic #(.PC_W(32), .IR_W(32), .DATA_W(64), .NOP_INST(32'h00000013), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_pc(in_pc), .in_ir(in_ir), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_ir(out_ir2),
        .out_data(out_data2), .occupancy(occupancy2), .kill_cnt(kill_cnt2)
    );

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic logic [63:0] data_of(input logic [31:0] pc);
        return {32'hD00D_0000 | pc, ~pc};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_ir    = ir_of(pc);
        in_data  = data_of(pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h40);
        #2;
        total_cnt++;
        if ({out_valid, occupancy, in_ready} !== 4'b0000) $display("FAIL reset_ctrl got v=%b occ=%0d rdy=%b want 0/0/0", out_valid, occupancy, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_ir !== NOP || out_pc !== 32'h0 || out_data !== 64'h0) $display("FAIL reset_out got ir=%h pc=%h data=%h want nop/0/0", out_ir, out_pc, out_data);
        else pass_cnt++;
        total_cnt++;
        if (kill_cnt !== 16'd0) $display("FAIL reset_kill got %0d want 0", kill_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_hold got out_valid=%b want 0", out_valid);
        else pass_cnt++;
        rst = 1'b1;
        drive(1'b0, 32'h0);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release got in_ready=%b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i));
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_ir !== ir_of(32'(4 * i)) ||
                out_data !== data_of(32'(4 * i)) || occupancy !== 2'd1)
                $display("FAIL stream_out[%0d] got v=%b pc=%h ir=%h occ=%0d want 1/%h/%h/1",
                         i, out_valid, out_pc, out_ir, occupancy, 4 * i, ir_of(32'(4 * i)));
            else pass_cnt++;
        end
        drive(1'b0, 32'h0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ir !== NOP || out_pc !== 32'h0 || out_data !== 64'h0)
            $display("FAIL stream_drain got v=%b occ=%0d ir=%h pc=%h want 0/0/nop/0", out_valid, occupancy, out_ir, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic        iv [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] ipc [8] = '{100, 104, 108, 108, 108, 108, 112, 0};
        logic        ordy [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        logic [1:0]  eocc [8] = '{1, 2, 2, 2, 1, 1, 1, 0};
        logic [31:0] epc [8] = '{100, 100, 100, 100, 104, 108, 112, 0};
        logic        erdy [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            drive(iv[i], ipc[i]);
            out_ready = ordy[i];
            step();
            total_cnt++;
            if (occupancy !== eocc[i] || out_valid !== (eocc[i] != 2'd0) || out_pc !== epc[i] ||
                out_ir !== ((eocc[i] == 2'd0) ? NOP : ir_of(epc[i])) || in_ready !== erdy[i])
                $display("FAIL bp[%0d] got occ=%0d v=%b pc=%0d ir=%h rdy=%b want occ=%0d pc=%0d rdy=%b",
                         i, occupancy, out_valid, out_pc, out_ir, in_ready, eocc[i], epc[i], erdy[i]);
            else pass_cnt++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h200); step();
        drive(1'b1, 32'h204); step();
        total_cnt++;
        if (occupancy !== 2'd2) $display("FAIL flush_fill got occ=%0d want 2", occupancy);
        else pass_cnt++;
        drive(1'b1, 32'h208);
        flush = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready);
        else pass_cnt++;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ir !== 32'h00000013 || out_pc !== 32'h0 || out_data !== 64'h0)
            $display("FAIL flush_empty got v=%b occ=%0d ir=%h pc=%h want 0/0/00000013/0", out_valid, occupancy, out_ir, out_pc);
        else pass_cnt++;
        total_cnt++;
        if (kill_cnt !== 16'd2) $display("FAIL flush_kill got %0d want 2", kill_cnt);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got out_valid=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'h300); step();
        drive(1'b1, 32'h304);
        stall = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_ir !== ir_of(32'h300) || occupancy !== 2'd1)
                $display("FAIL stall_hold[%0d] got v=%b pc=%h occ=%0d want 1/300/1", i, out_valid, out_pc, occupancy);
            else pass_cnt++;
        end
        stall = 1'b0;
        drive(1'b0, 32'h0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL stall_release got v=%b occ=%0d want 0/0", out_valid, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_kill_saturate();
        logic [15:0] e1 [3] = '{2, 4, 6};
        logic [1:0]  e2 [3] = '{2, 3, 3};
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            drive(1'b1, 32'(32'h400 + 8 * r)); step();
            drive(1'b1, 32'(32'h404 + 8 * r)); step();
            drive(1'b0, 32'h0);
            flush = 1'b1;
            stall = (r == 2);   // flush must win over stall
            step();
            flush = 1'b0;
            stall = 1'b0;
            total_cnt++;
            if (kill_cnt !== e1[r] || kill_cnt2 !== e2[r] || occupancy !== 2'd0)
                $display("FAIL kill[%0d] got k16=%0d k2=%0d occ=%0d want %0d/%0d/0", r, kill_cnt, kill_cnt2, occupancy, e1[r], e2[r]);
            else pass_cnt++;
        end
        out_ready = 1'b0;
        drive(1'b1, 32'h500); step();
        drive(1'b0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if (kill_cnt !== 16'd7 || kill_cnt2 !== 2'd3) $display("FAIL kill_one got k16=%0d k2=%0d want 7/3", kill_cnt, kill_cnt2);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total_cnt++;
        if (kill_cnt !== 16'd7 || kill_cnt2 !== 2'd3 || out_valid2 !== 1'b0 || occupancy2 !== 2'd0 ||
            out_ir2 !== NOP || out_pc2 !== 32'h0 || out_data2 !== 64'h0 || in_ready2 !== 1'b1)
            $display("FAIL kill_empty got k16=%0d k2=%0d v2=%b occ2=%0d ir2=%h rdy2=%b want 7/3/0/0/nop/1",
                     kill_cnt, kill_cnt2, out_valid2, occupancy2, out_ir2, in_ready2);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h600); step();
        drive(1'b1, 32'h604); step();
        drive(1'b1, 32'h608);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ir !== NOP || in_ready !== 1'b0 || kill_cnt !== 16'd0)
            $display("FAIL async_rst got v=%b occ=%0d ir=%h rdy=%b kill=%0d want 0/0/nop/0/0", out_valid, occupancy, out_ir, in_ready, kill_cnt);
        else pass_cnt++;
        step();
        #1 rst = 1'b1;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL async_release got rdy=%b v=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 32'h608 || occupancy !== 2'd1) $display("FAIL async_resume got v=%b pc=%h occ=%0d want 1/608/1", out_valid, out_pc, occupancy);
        else pass_cnt++;
        drive(1'b0, 32'h0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL async_drain got v=%b occ=%0d want 0/0", out_valid, occupancy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_stall();
        test_kill_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
